// File: rtl/screen_pkg.sv
// -----------------------------------------------------------------------------
// screen_pkg
// Shared definitions for the frame-buffer writer: default screen geometry,
// bus widths, the writer FSM state encoding and a saturating counter helper.
// No ports (package).
// -----------------------------------------------------------------------------
package screen_pkg;

  // Default screen geometry; the product must stay within the 15-bit address space.
  localparam int SCREEN_W      = 160;
  localparam int SCREEN_H      = 120;
  localparam int SCREEN_PIXELS = SCREEN_W * SCREEN_H;  // 19200

  localparam int ADDR_W   = 15;
  localparam int COORD_W  = 10;
  localparam int COLOUR_W = 3;

  // Ceiling for the accepted-plot counter.
  localparam logic [ADDR_W-1:0] COUNT_MAX = 15'h7FFF;

  // Writer FSM encoding.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Increment that sticks at COUNT_MAX instead of wrapping.
  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] value);
    logic [ADDR_W-1:0] result;
    if (value == COUNT_MAX) begin
      result = value;
    end else begin
      result = value + 15'd1;
    end
    return result;
  endfunction

endpackage : screen_pkg

// File: rtl/screen_addr.sv
// -----------------------------------------------------------------------------
// screen_addr
// Combinational coordinate-to-linear-address conversion: addr = y*WIDTH + x.
// For the default 160-pixel width the multiply is replaced by two shifts
// (y*128 + y*32), which is cheaper than a generic multiplier.
//
// Ports
//   x    : in  [9:0]  pixel column
//   y    : in  [9:0]  pixel row
//   addr : out [14:0] linear RAM address (valid for in-range coordinates)
// -----------------------------------------------------------------------------
module screen_addr
  import screen_pkg::*;
#(
  parameter int WIDTH = screen_pkg::SCREEN_W
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [ADDR_W-1:0]  addr
);

  logic [ADDR_W-1:0] x_ext_s;
  logic [ADDR_W-1:0] y_ext_s;

  // Widen before any arithmetic so the shifted row term never loses upper bits.
  assign x_ext_s = {5'd0, x};
  assign y_ext_s = {5'd0, y};

  generate
    if (WIDTH == 160) begin : g_shift
      assign addr = (y_ext_s << 4'd7) + (y_ext_s << 4'd5) + x_ext_s;
    end else begin : g_mult
      assign addr = (y_ext_s * ADDR_W'(WIDTH)) + x_ext_s;
    end
  endgenerate

endmodule : screen_addr

// File: rtl/screen_writer.sv
// -----------------------------------------------------------------------------
// screen_writer
// Front end for a pixel frame buffer. In IDLE it turns (x, y, colour) plot
// strobes into single RAM writes one cycle later; a clear request switches to
// CLEAR, where the whole buffer is filled with a latched colour at one write
// per cycle. Out-of-range plots, plots that collide with a clear, and plots
// issued during a fill are discarded and flagged on the sticky drop output.
// All outputs are registered; reset is synchronous and active-low.
// SCREEN_W*SCREEN_H must not exceed 32768.
//
// Ports
//   clk          : in  clock, everything on the rising edge
//   resetn       : in  synchronous active-low reset
//   plot         : in  pixel-valid strobe
//   x, y         : in  [9:0] pixel column / row
//   colour       : in  [2:0] pixel colour
//   clear        : in  single-cycle fill request
//   clear_colour : in  [2:0] fill colour, sampled when clear is accepted
//   mem_address  : out [14:0] RAM write address
//   mem_data     : out [2:0]  RAM write data
//   mem_wren     : out RAM write enable
//   busy         : out high while a fill is in progress
//   done         : out one-cycle pulse when a fill completes
//   drop         : out sticky rejected-plot flag
//   pixel_count  : out [14:0] accepted plots since reset / last clear (saturating)
// -----------------------------------------------------------------------------
module screen_writer
  import screen_pkg::*;
#(
  parameter int SCREEN_W = screen_pkg::SCREEN_W,
  parameter int SCREEN_H = screen_pkg::SCREEN_H
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                plot,
  input  logic [COORD_W-1:0]  x,
  input  logic [COORD_W-1:0]  y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                clear,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_wren,
  output logic                busy,
  output logic                done,
  output logic                drop,
  output logic [ADDR_W-1:0]   pixel_count
);

  localparam int                PIXELS    = SCREEN_W * SCREEN_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
  // 32-bit limits so the range test holds for any geometry that fits the RAM.
  localparam logic [31:0]       X_LIM     = 32'(SCREEN_W);
  localparam logic [31:0]       Y_LIM     = 32'(SCREEN_H);

  // Internal state
  state_t                state_r;
  logic [ADDR_W-1:0]     fill_r;
  logic [COLOUR_W-1:0]   colour_r;

  // Next-state values
  state_t                state_s;
  logic [ADDR_W-1:0]     fill_s;
  logic [COLOUR_W-1:0]   colour_s;
  logic [ADDR_W-1:0]     mem_address_s;
  logic [COLOUR_W-1:0]   mem_data_s;
  logic                  mem_wren_s;
  logic                  busy_s;
  logic                  done_s;
  logic                  drop_s;
  logic [ADDR_W-1:0]     pixel_count_s;

  // Plot decode
  logic [ADDR_W-1:0]     plot_addr_s;
  logic                  in_range_s;

  screen_addr #(
    .WIDTH (SCREEN_W)
  ) u_screen_addr (
    .x    (x),
    .y    (y),
    .addr (plot_addr_s)
  );

  assign in_range_s = ({22'd0, x} < X_LIM) && ({22'd0, y} < Y_LIM);

  // Next-state and next-output logic for the IDLE/CLEAR machine.
  always_comb begin
    state_s       = state_r;
    fill_s        = fill_r;
    colour_s      = colour_r;
    mem_address_s = 15'd0;
    mem_data_s    = 3'd0;
    mem_wren_s    = 1'b0;
    busy_s        = 1'b0;
    done_s        = 1'b0;
    drop_s        = drop;
    pixel_count_s = pixel_count;

    case (state_r)
      IDLE: begin
        if (clear) begin
          // Clear wins over a simultaneous plot; that plot is the only thing
          // that can leave drop set after accepting the clear.
          state_s       = CLEAR;
          fill_s        = 15'd0;
          colour_s      = clear_colour;
          pixel_count_s = 15'd0;
          busy_s        = 1'b1;
          drop_s        = plot;
        end else if (plot) begin
          if (in_range_s) begin
            mem_wren_s    = 1'b1;
            mem_address_s = plot_addr_s;
            mem_data_s    = colour;
            pixel_count_s = sat_inc(pixel_count);
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end

      CLEAR: begin
        // One fill write per cycle; clear requests are ignored here.
        mem_wren_s    = 1'b1;
        mem_address_s = fill_r;
        mem_data_s    = colour_r;
        if (plot) begin
          drop_s = 1'b1;
        end else begin
          drop_s = drop;
        end
        if (fill_r == LAST_ADDR) begin
          // Final write goes out together with done and busy falling.
          state_s = IDLE;
          fill_s  = 15'd0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          fill_s = fill_r + 15'd1;
          busy_s = 1'b1;
        end
      end

      default: begin
        state_s = IDLE;
        fill_s  = 15'd0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset; reset
  // mid-fill simply abandons the fill with no done pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= IDLE;
      fill_r      <= 15'd0;
      colour_r    <= 3'd0;
      mem_address <= 15'd0;
      mem_data    <= 3'd0;
      mem_wren    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      drop        <= 1'b0;
      pixel_count <= 15'd0;
    end else begin
      state_r     <= state_s;
      fill_r      <= fill_s;
      colour_r    <= colour_s;
      mem_address <= mem_address_s;
      mem_data    <= mem_data_s;
      mem_wren    <= mem_wren_s;
      busy        <= busy_s;
      done        <= done_s;
      drop        <= drop_s;
      pixel_count <= pixel_count_s;
    end
  end

endmodule : screen_writer

// File: doc/screen_writer.md
SCREEN_WRITER -- requirements
Module: screen_writer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, meaning pixel columns.
REQ-002 SHALL have parameter SCREEN_H, default 120, meaning pixel rows; SCREEN_W*SCREEN_H SHALL NOT exceed 32768.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on posedge.
REQ-004 SHALL have port resetn, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port plot, input, 1: pixel-valid strobe; one pixel per cycle when high.
REQ-006 SHALL have port x, input, 10: pixel column.
REQ-007 SHALL have port y, input, 10: pixel row.
REQ-008 SHALL have port colour, input, 3: pixel colour.
REQ-009 SHALL have port clear, input, 1: single-cycle request to fill the whole screen.
REQ-010 SHALL have port clear_colour, input, 3: fill colour, sampled in the cycle clear is accepted.
REQ-011 SHALL have port mem_address, output, 15: RAM write address.
REQ-012 SHALL have port mem_data, output, 3: RAM write data.
REQ-013 SHALL have port mem_wren, output, 1: RAM write enable.
REQ-014 SHALL have port busy, output, 1: high while a clear is in progress.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when a clear completes.
REQ-016 SHALL have port drop, output, 1: sticky flag for a rejected plot.
REQ-017 SHALL have port pixel_count, output, 15: plot writes accepted since reset or the last clear.

Function
REQ-018 SHALL implement FSM states IDLE and CLEAR.
REQ-019 SHALL accept a plot in IDLE when x<SCREEN_W and y<SCREEN_H, with no clear in the same cycle.
REQ-020 SHALL write an accepted plot on the next cycle: mem_wren=1, mem_address=y*SCREEN_W+x, mem_data=colour (one-cycle latency, registered outputs).
REQ-021 SHALL suppress the write for an out-of-range plot, set drop, and leave pixel_count unchanged.
REQ-022 SHALL, on clear in IDLE, latch clear_colour, enter CLEAR, zero the fill counter, zero pixel_count and raise busy on the next cycle.
REQ-023 SHALL make one write per cycle in CLEAR: mem_address = fill counter 0..SCREEN_W*SCREEN_H-1, mem_data = latched colour, mem_wren=1.
REQ-024 SHALL, after the write to address SCREEN_W*SCREEN_H-1, return to IDLE, drop busy and pulse done for exactly one cycle.
REQ-025 SHALL give clear priority when clear and plot arrive together in IDLE; the plot is dropped and drop is set.
REQ-026 SHALL ignore any plot during CLEAR and set drop.
REQ-027 SHALL ignore clear during CLEAR; the fill does not restart.
REQ-028 SHALL clear drop only by reset or by acceptance of a clear.
REQ-029 SHALL saturate pixel_count at 32767.
REQ-030 SHALL compute all addresses in 15 bits with no truncation for in-range coordinates.
REQ-031 SHALL drive mem_wren=0 in every cycle with no write.

Reset
REQ-032 SHALL, while resetn=0 at a clock edge, set the state to IDLE, and clear the fill counter, latched colour, mem_address, mem_data, mem_wren, busy, done, drop and pixel_count to 0.
REQ-033 SHALL abort a CLEAR when reset arrives mid-fill: no further writes and no done pulse.

Structure
REQ-034 SHALL take SCREEN_W, SCREEN_H, SCREEN_PIXELS (19200) and the FSM state encoding from a shared screen package.
REQ-035 SHALL place the coordinate-to-address arithmetic in sub-module screen_addr, computing y*160+x as (y<<7)+(y<<5)+x at default width.

Verification
REQ-036 SHALL cover: plot x=5,y=2,colour=3'b101 in IDLE -> next cycle mem_wren=1, mem_address=325, mem_data=5, pixel_count=1.
REQ-037 SHALL cover: clear with clear_colour=3'b010 -> busy for 19200 cycles; addresses 0..19199 written with 2; done pulses once; pixel_count=0.
REQ-038 SHALL cover: plot x=160,y=0 and, separately, x=0,y=120 -> no write; drop=1.
REQ-039 SHALL cover: clear and plot in the same cycle, then plot at fill counter 100 -> fill completes unaltered; drop=1; no plot write appears.
REQ-040 SHALL cover: resetn=0 at fill counter 5000 -> mem_wren=0 and busy=0 next cycle; no done pulse; IDLE resumes.
REQ-041 SHALL cover: plot x=159,y=119 -> mem_address=19199.
